// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline stall/flush/interrupt sequencer.
// Optional feature macro: PIPELINE_HAZARD_STALL_CNT_EN (bubble-cycle counter).
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_STALL     = 3'd1,
        ST_PUSH_HI   = 3'd2,
        ST_PUSH_LO   = 3'd3,
        ST_INT_FETCH = 3'd4
    } hz_state_e;

    localparam logic [3:0] NONE_REG           = 4'hF;
    localparam int         INT_VEC_CYCLES_DEF = 1;

    localparam logic [1:0] PUSH_NONE   = 2'b00;
    localparam logic [1:0] PUSH_PC_HI  = 2'b01;
    localparam logic [1:0] PUSH_PC_LO  = 2'b10;
    localparam logic [1:0] PUSH_VECTOR = 2'b11;

    // Saturating 16-bit increment, holds at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-register fields in, pipeline enables/flushes and push select out.
// stall_cnt exists only when PIPELINE_HAZARD_STALL_CNT_EN is defined.
interface pipeline_hazard_ctrl_if;

    logic       de_mem_read;
    logic [3:0] de_reg_dst_num;
    logic [2:0] fd_src1_num;
    logic [3:0] fd_src2_num;
    logic       fd_uses_src1;
    logic       fd_uses_src2;
    logic       branch_taken;
    logic       int_req;
    logic       pc_en;
    logic       fd_en;
    logic       fd_flush;
    logic       de_en;
    logic       int_ack;
    logic [1:0] push_sel;
`ifdef PIPELINE_HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    modport master (
        output de_mem_read, de_reg_dst_num, fd_src1_num, fd_src2_num,
        output fd_uses_src1, fd_uses_src2, branch_taken, int_req,
`ifdef PIPELINE_HAZARD_STALL_CNT_EN
        input  stall_cnt,
`endif
        input  pc_en, fd_en, fd_flush, de_en, int_ack, push_sel
    );

    modport slave (
        input  de_mem_read, de_reg_dst_num, fd_src1_num, fd_src2_num,
        input  fd_uses_src1, fd_uses_src2, branch_taken, int_req,
`ifdef PIPELINE_HAZARD_STALL_CNT_EN
        output stall_cnt,
`endif
        output pc_en, fd_en, fd_flush, de_en, int_ack, push_sel
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Combinational load-use compare; also usable for forwarding-match checks.
module hazard_cmp
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       mem_read,
    input  logic [3:0] dst_num,
    input  logic [2:0] src1_num,
    input  logic [3:0] src2_num,
    input  logic       uses_src1,
    input  logic       uses_src2,
    output logic       hazard
);

    logic src1_hit_s;
    logic src2_hit_s;

    // Source 1 is only 3 bits wide, so it can never alias NONE_REG.
    assign src1_hit_s = uses_src1 & ({1'b0, src1_num} == dst_num);
    assign src2_hit_s = uses_src2 & (src2_num == dst_num);
    assign hazard     = mem_read & (dst_num != NONE_REG) & (src1_hit_s | src2_hit_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/interrupt-entry sequencer for the five-stage pipeline.
// Define PIPELINE_HAZARD_STALL_CNT_EN to add the saturating stall_cnt output.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int INT_VEC_CYCLES = INT_VEC_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz
);

    hz_state_e  state_r;
    hz_state_e  state_nxt_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_nxt_s;
    logic       hazard_s;
    logic       pc_en_s;
    logic       fd_en_s;
    logic       fd_flush_s;
    logic       de_en_s;
    logic       int_ack_s;
    logic [1:0] push_sel_s;

    hazard_cmp u_hazard_cmp (
        .mem_read  (hz.de_mem_read),
        .dst_num   (hz.de_reg_dst_num),
        .src1_num  (hz.fd_src1_num),
        .src2_num  (hz.fd_src2_num),
        .uses_src1 (hz.fd_uses_src1),
        .uses_src2 (hz.fd_uses_src2),
        .hazard    (hazard_s)
    );

    // State and vector-wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next state and pipeline controls; RUN decisions are same-cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pc_en_s     = 1'b1;
        fd_en_s     = 1'b1;
        fd_flush_s  = 1'b0;
        de_en_s     = 1'b1;
        int_ack_s   = 1'b0;
        push_sel_s  = PUSH_NONE;
        case (state_r)
            ST_RUN: begin
                if (hz.branch_taken) begin
                    fd_flush_s = 1'b1;
                    de_en_s    = 1'b0;
                end else if (hazard_s) begin
                    pc_en_s     = 1'b0;
                    fd_en_s     = 1'b0;
                    de_en_s     = 1'b0;
                    state_nxt_s = ST_STALL;
                end else if (hz.int_req) begin
                    int_ack_s   = 1'b1;
                    pc_en_s     = 1'b0;
                    fd_flush_s  = 1'b1;
                    de_en_s     = 1'b0;
                    state_nxt_s = ST_PUSH_HI;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            // The load has already left DE, so no hazard re-check here.
            ST_STALL: begin
                state_nxt_s = ST_RUN;
            end
            ST_PUSH_HI: begin
                push_sel_s  = PUSH_PC_HI;
                pc_en_s     = 1'b0;
                fd_en_s     = 1'b0;
                de_en_s     = 1'b0;
                state_nxt_s = ST_PUSH_LO;
            end
            ST_PUSH_LO: begin
                push_sel_s  = PUSH_PC_LO;
                pc_en_s     = 1'b0;
                fd_en_s     = 1'b0;
                de_en_s     = 1'b0;
                cnt_nxt_s   = 3'(INT_VEC_CYCLES - 1);
                state_nxt_s = ST_INT_FETCH;
            end
            ST_INT_FETCH: begin
                push_sel_s = PUSH_VECTOR;
                fd_en_s    = 1'b0;
                de_en_s    = 1'b0;
                if (cnt_r == 3'd0) begin
                    pc_en_s     = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    pc_en_s   = 1'b0;
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    assign hz.pc_en    = pc_en_s;
    assign hz.fd_en    = fd_en_s;
    assign hz.fd_flush = fd_flush_s;
    assign hz.de_en    = de_en_s;
    assign hz.int_ack  = int_ack_s;
    assign hz.push_sel = push_sel_s;

`ifdef PIPELINE_HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Count every cycle in which DE receives a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 16'd0;
        end else if (!de_en_s) begin
            stall_cnt_r <= sat_inc16(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign hz.stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (INT_VEC_CYCLES=1).
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.INT_VEC_CYCLES(1)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected vector order: {pc_en, fd_en, fd_flush, de_en, int_ack, push_sel}
    task automatic check_outs(input string tag, input logic [6:0] exp);
        check_eq(tag, {25'd0, hz.pc_en, hz.fd_en, hz.fd_flush, hz.de_en, hz.int_ack, hz.push_sel},
                 {25'd0, exp});
    endtask

    task automatic set_in(input logic mr, input logic [3:0] dst, input logic u1, input logic [2:0] s1,
                          input logic u2, input logic [3:0] s2, input logic br, input logic irq);
        hz.de_mem_read    = mr;
        hz.de_reg_dst_num = dst;
        hz.fd_uses_src1   = u1;
        hz.fd_src1_num    = s1;
        hz.fd_uses_src2   = u2;
        hz.fd_src2_num    = s2;
        hz.branch_taken   = br;
        hz.int_req        = irq;
    endtask

    task automatic set_idle();
        set_in(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // Check at the falling edge, then advance just past the next rising edge.
    task automatic cyc(input string tag, input logic [6:0] exp);
        @(negedge clk);
        check_outs(tag, exp);
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] O_IDLE   = 7'b1101000;
    localparam logic [6:0] O_BUBBLE = 7'b0000000;
    localparam logic [6:0] O_BRANCH = 7'b1110000;
    localparam logic [6:0] O_ACK    = 7'b0110100;
    localparam logic [6:0] O_PUSHHI = 7'b0000001;
    localparam logic [6:0] O_PUSHLO = 7'b0000010;
    localparam logic [6:0] O_VECTOR = 7'b1000011;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        set_idle();
        #3;
        check_outs("reset_outs", O_IDLE);
`ifdef PIPELINE_HAZARD_STALL_CNT_EN
        check_eq("reset_cnt", {16'd0, hz.stall_cnt}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        cyc("idle", O_IDLE);

        // Load-use on source 1; inputs kept in the stall cycle to prove no re-check.
        set_in(1'b1, 4'd3, 1'b1, 3'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc("lu_bubble", O_BUBBLE);
        cyc("lu_stall_one", O_IDLE);
        set_idle();
        cyc("lu_after", O_IDLE);

        set_in(1'b1, 4'hF, 1'b0, 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);
        cyc("none_reg", O_IDLE);
        set_in(1'b1, 4'd3, 1'b0, 3'd0, 1'b1, 4'd4, 1'b0, 1'b0);
        cyc("src2_nomatch", O_IDLE);
        set_in(1'b1, 4'd3, 1'b0, 3'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc("src1_unused", O_IDLE);
        set_in(1'b0, 4'd3, 1'b1, 3'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc("not_load", O_IDLE);
        set_in(1'b1, 4'd4, 1'b0, 3'd0, 1'b1, 4'd4, 1'b0, 1'b0);
        cyc("src2_bubble", O_BUBBLE);
        set_idle();
        cyc("src2_stall", O_IDLE);

        // Branch beats hazard; a fresh hazard next cycle proves we stayed in RUN.
        set_in(1'b1, 4'd3, 1'b1, 3'd3, 1'b0, 4'd0, 1'b1, 1'b0);
        cyc("br_hz", O_BRANCH);
        set_in(1'b1, 4'd3, 1'b1, 3'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc("br_no_stall", O_BUBBLE);
        set_idle();
        cyc("br_stall", O_IDLE);

        set_in(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1);
        cyc("br_over_int", O_BRANCH);

        // Hazard beats interrupt; interrupt ignored while in STALL.
        set_in(1'b1, 4'd3, 1'b1, 3'd3, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc("hz_over_int", O_BUBBLE);
        set_in(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc("int_in_stall", O_IDLE);
        cyc("int_ack", O_ACK);
        set_in(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1);
        cyc("push_hi", O_PUSHHI);
        cyc("push_lo", O_PUSHLO);
        set_idle();
        cyc("int_fetch", O_VECTOR);
        cyc("int_done", O_IDLE);

        // Reset in the middle of PUSH_LO aborts immediately.
        set_in(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc("ack2", O_ACK);
        cyc("push_hi2", O_PUSHHI);
        @(negedge clk);
        check_outs("push_lo2", O_PUSHLO);
        #2;
        hz.int_req = 1'b0;
        reset      = 1'b0;
        #1;
        check_outs("rst_abort", O_IDLE);
        @(posedge clk);
        #1;
        check_outs("rst_hold", O_IDLE);
        #1;
        reset      = 1'b1;
        hz.int_req = 1'b1;
        cyc("re_ack", O_ACK);
        set_idle();
        cyc("re_push_hi", O_PUSHHI);
        cyc("re_push_lo", O_PUSHLO);
        cyc("re_fetch", O_VECTOR);
        cyc("re_done", O_IDLE);

`ifdef PIPELINE_HAZARD_STALL_CNT_EN
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("cnt_cleared", {16'd0, hz.stall_cnt}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4'd3, 1'b1, 3'd3, 1'b0, 4'd0, 1'b0, 1'b0);
            cyc("cnt_lu", O_BUBBLE);
            set_idle();
            cyc("cnt_stall", O_IDLE);
        end
        set_in(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        cyc("cnt_br", O_BRANCH);
        set_idle();
        check_eq("cnt_four", {16'd0, hz.stall_cnt}, 32'd4);
        hz.branch_taken = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        hz.branch_taken = 1'b0;
        check_eq("cnt_sat", {16'd0, hz.stall_cnt}, 32'h0000FFFF);
        @(posedge clk);
        #1;
        check_eq("cnt_sat_hold", {16'd0, hz.stall_cnt}, 32'h0000FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
